// File: rtl/lvds_pkg.sv
// rtl/lvds_pkg.sv - constants, pixel type and lane-mapping functions for lvds_panel_tx
// bar_color exists only when LVDS_TESTPATTERN_EN is defined.
package lvds_pkg;

  localparam logic [6:0] CLK_PATTERN   = 7'b1100011;
  localparam int         BITS_PER_SLOT = 7;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef logic [3:0][6:0] lane_words_t;

  function automatic lane_words_t map_vesa(input rgb_t p, input logic de, input logic hs, input logic vs);
    lane_words_t w;
    w[0] = {p.g[0], p.r[5:0]};
    w[1] = {p.b[1:0], p.g[5:1]};
    w[2] = {de, vs, hs, p.b[5:2]};
    w[3] = {1'b0, p.b[7:6], p.g[7:6], p.r[7:6]};
    return w;
  endfunction

  // Upper six bits of each colour ride lanes 0-2; the two LSBs go to lane 3.
  function automatic lane_words_t map_jeida(input rgb_t p, input logic de, input logic hs, input logic vs);
    lane_words_t w;
    w[0] = {p.g[2], p.r[7:2]};
    w[1] = {p.b[3:2], p.g[7:3]};
    w[2] = {de, vs, hs, p.b[7:4]};
    w[3] = {1'b0, p.b[1:0], p.g[1:0], p.r[1:0]};
    return w;
  endfunction

  function automatic lane_words_t map_18(input rgb_t p, input logic de, input logic hs, input logic vs);
    lane_words_t w;
    w    = map_jeida(p, de, hs, vs);
    w[3] = '0;
    return w;
  endfunction

`ifdef LVDS_TESTPATTERN_EN
  function automatic rgb_t bar_color(input int idx);
    case (idx)
      0:       bar_color = 24'hFFFFFF;
      1:       bar_color = 24'hFFFF00;
      2:       bar_color = 24'h00FFFF;
      3:       bar_color = 24'h00FF00;
      4:       bar_color = 24'hFF00FF;
      5:       bar_color = 24'hFF0000;
      6:       bar_color = 24'h0000FF;
      default: bar_color = 24'h000000;
    endcase
  endfunction
`endif

endpackage

// File: rtl/lvds_timing_gen.sv
// rtl/lvds_timing_gen.sv - phase/pixel/line counters, DE/HS/VS, frame_start and pix_rd strobe
// hpos output exists only when LVDS_TESTPATTERN_EN is defined.
module lvds_timing_gen
  import lvds_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 29,
  parameter int SYNC_POL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  output logic        slot_start,
  output logic        slot_last,
  output logic        de,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
`ifdef LVDS_TESTPATTERN_EN
  output logic [15:0] hpos,
`endif
  output logic        pix_rd
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = (H_TOTAL > 2) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_TOTAL > 2) ? $clog2(V_TOTAL) : 1;
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [2:0]    PH_LAST = 3'(BITS_PER_SLOT - 1);
  localparam logic          POL     = (SYNC_POL != 0);

  logic [2:0]    ph_q, ph_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  int            h, v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q   <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      ph_q   <= ph_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  always_comb begin
    ph_d   = ph_q + 3'd1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (ph_q == PH_LAST) begin
      ph_d = '0;
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  // Strobes are masked while rst is high so every output reads 0 in reset.
  always_comb begin
    h           = int'(hcnt_q);
    v           = int'(vcnt_q);
    slot_start  = (ph_q == 3'd0);
    slot_last   = (ph_q == PH_LAST);
    de          = (h < H_ACTIVE) && (v < V_ACTIVE);
    hs          = ((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC)) ? POL : ~POL;
    vs          = ((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC)) ? POL : ~POL;
    frame_start = ~rst & slot_start & (hcnt_q == '0) & (vcnt_q == '0);
    pix_rd      = ~rst & rd_en & slot_start & de;
  end

`ifdef LVDS_TESTPATTERN_EN
  assign hpos = 16'(hcnt_q);
`endif

endmodule

// File: rtl/lvds_panel_tx.sv
// rtl/lvds_panel_tx.sv - LVDS panel transmitter top: pixel capture, lane mapping, 7:1 serialisers
// Defining LVDS_TESTPATTERN_EN adds the pattern_en input and internal colour bars.
module lvds_panel_tx
  import lvds_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int JEIDA    = 0,
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 29,
  parameter int SYNC_POL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [23:0]      pix_data,
  input  logic             pix_valid,
`ifdef LVDS_TESTPATTERN_EN
  input  logic             pattern_en,
`endif
  output logic             pix_rd,
  output logic             frame_start,
  output logic             underrun,
  output logic [LANES-1:0] dout,
  output logic             clkout
);

  logic slot_start, slot_last, de, hs, vs, rd_en;
  logic miss;
  rgb_t rgb;
  lane_words_t lanes;

  logic [LANES-1:0][6:0] word_q, word_d;
  logic [LANES-1:0][6:0] sh_q, sh_d;
  logic [6:0]            clk_sh_q, clk_sh_d;
  logic                  underrun_q, underrun_d;

`ifdef LVDS_TESTPATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic [15:0] hpos;
  assign rd_en = ~pattern_en;
`else
  assign rd_en = 1'b1;
`endif

  lvds_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .slot_start  (slot_start),
    .slot_last   (slot_last),
    .de          (de),
    .hs          (hs),
    .vs          (vs),
    .frame_start (frame_start),
`ifdef LVDS_TESTPATTERN_EN
    .hpos        (hpos),
`endif
    .pix_rd      (pix_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q     <= '0;
      sh_q       <= '0;
      clk_sh_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      word_q     <= word_d;
      sh_q       <= sh_d;
      clk_sh_q   <= clk_sh_d;
      underrun_q <= underrun_d;
    end
  end

  // A missing pixel still occupies its DE slot, just with black colour.
  always_comb begin
    rgb  = '0;
    miss = 1'b0;
`ifdef LVDS_TESTPATTERN_EN
    if (pattern_en) begin
      if (de) rgb = bar_color(int'(hpos) / BAR_W);
    end else
`endif
    if (de) begin
      if (pix_valid) rgb = rgb_t'(pix_data);
      else           miss = 1'b1;
    end

    if (LANES == 3)      lanes = map_18(rgb, de, hs, vs);
    else if (JEIDA != 0) lanes = map_jeida(rgb, de, hs, vs);
    else                 lanes = map_vesa(rgb, de, hs, vs);

    word_d     = slot_start ? lanes[LANES-1:0] : word_q;
    underrun_d = underrun_q | (slot_start & miss);
  end

  // Word captured at ph 0 moves into the shifters on the ph 6 edge, bit6 first.
  always_comb begin
    sh_d     = sh_q;
    clk_sh_d = slot_last ? CLK_PATTERN : {clk_sh_q[5:0], 1'b0};
    for (int l = 0; l < LANES; l++) begin
      sh_d[l] = slot_last ? word_q[l] : {sh_q[l][5:0], 1'b0};
    end
  end

  always_comb begin
    dout = '0;
    for (int l = 0; l < LANES; l++) begin
      dout[l] = sh_q[l][6];
    end
  end

  assign clkout   = clk_sh_q[6];
  assign underrun = underrun_q;

endmodule

// File: tb/tb_lvds_panel_tx.sv
// tb/tb_lvds_panel_tx.sv - randomized self-checking bench for lvds_panel_tx (4-lane VESA, small timing)
// pattern_en is tied low when LVDS_TESTPATTERN_EN is defined.
module tb_lvds_panel_tx;

  localparam int HA = 4, HF = 1, HSW = 1, HB = 1;
  localparam int VA = 2, VF = 1, VSW = 1, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT * 7;
  localparam logic SP = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_rd, frame_start, underrun, clkout;
  logic [3:0]  dout;
`ifdef LVDS_TESTPATTERN_EN
  logic        pattern_en = 1'b0;
`endif

  int          checks = 0;
  int          errors = 0;
  int          t = 0;
  logic [27:0] cur_word = '0;
  logic [27:0] prev_word = '0;
  logic        prev_ok = 1'b0;
  logic        exp_under = 1'b0;
  logic [6:0]  clk_ref = 7'b1100011;

  always #5 clk = ~clk;

  lvds_panel_tx #(
    .LANES(4), .JEIDA(0),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .SYNC_POL(0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
`ifdef LVDS_TESTPATTERN_EN
    .pattern_en  (pattern_en),
`endif
    .pix_rd      (pix_rd),
    .frame_start (frame_start),
    .underrun    (underrun),
    .dout        (dout),
    .clkout      (clkout)
  );

  // Expected 4 lane words {l3,l2,l1,l0} of the slot containing cycle tt.
  function automatic logic [27:0] exp_word(input int tt, input logic [23:0] p, input logic v);
    int f, h, vl;
    logic de, hs, vs;
    logic [7:0] r, g, b;
    logic [6:0] l0, l1, l2, l3;
    f  = (tt / 7) % (HT * VT);
    h  = f % HT;
    vl = f / HT;
    de = (h < HA) && (vl < VA);
    hs = (h >= HA + HF && h < HA + HF + HSW) ? SP : ~SP;
    vs = (vl >= VA + VF && vl < VA + VF + VSW) ? SP : ~SP;
    {r, g, b} = (de && v) ? p : 24'h0;
    l0 = {g[0], r[5:0]};
    l1 = {b[1:0], g[5:1]};
    l2 = {de, vs, hs, b[5:2]};
    l3 = {1'b0, b[7:6], g[7:6], r[7:6]};
    return {l3, l2, l1, l0};
  endfunction

  // One clock: compare outputs against the model, then drive the next pixel.
  task automatic step(input int drop_pct, input bit fixed, input logic [23:0] fixed_pix, input int miss_slot);
    int ph, f, h, vl;
    logic exp_rd, exp_fs, exp_clk, v;
    logic [3:0] exp_dout;
    logic [23:0] p;
    @(negedge clk);
    ph = t % 7;
    f  = (t / 7) % (HT * VT);
    h  = f % HT;
    vl = f / HT;
    if (ph == 0) begin
      prev_word = cur_word;
      prev_ok   = (t >= 7);
    end
    exp_rd   = (ph == 0) && (h < HA) && (vl < VA);
    exp_fs   = (t % FRAME == 0);
    exp_dout = '0;
    exp_clk  = 1'b0;
    if (prev_ok) begin
      for (int l = 0; l < 4; l++) exp_dout[l] = prev_word[l * 7 + (6 - ph)];
      exp_clk = clk_ref[6 - ph];
    end
    checks++;
    if (pix_rd !== exp_rd) begin
      errors++;
      $display("FAIL pix_rd t=%0d got %b expected %b", t, pix_rd, exp_rd);
    end
    checks++;
    if (frame_start !== exp_fs) begin
      errors++;
      $display("FAIL frame_start t=%0d got %b expected %b", t, frame_start, exp_fs);
    end
    checks++;
    if (underrun !== exp_under) begin
      errors++;
      $display("FAIL underrun t=%0d got %b expected %b", t, underrun, exp_under);
    end
    checks++;
    if (dout !== exp_dout) begin
      errors++;
      $display("FAIL dout t=%0d got %b expected %b", t, dout, exp_dout);
    end
    checks++;
    if (clkout !== exp_clk) begin
      errors++;
      $display("FAIL clkout t=%0d got %b expected %b", t, clkout, exp_clk);
    end
    p = fixed ? fixed_pix : 24'($urandom());
    v = ($urandom_range(99) >= drop_pct);
    if (t / 7 == miss_slot) v = 1'b0;
    pix_data  = p;
    pix_valid = v;
    if (ph == 0) begin
      cur_word = exp_word(t, p, v);
      if (exp_rd && !v) exp_under = 1'b1;
    end
    @(posedge clk);
    t++;
  endtask

  // Called just after a rising edge: holds rst for n clocks, checks quiet outputs, then releases.
  task automatic apply_reset(input int n);
    #1 rst = 1'b1;
    repeat (n) begin
      @(negedge clk);
      checks++;
      if ({pix_rd, frame_start, underrun, dout, clkout} !== 8'b0) begin
        errors++;
        $display("FAIL in_reset got rd=%b fs=%b ur=%b dout=%b clk=%b expected all 0",
                 pix_rd, frame_start, underrun, dout, clkout);
      end
      @(posedge clk);
    end
    #1 rst = 1'b0;
    t = 0;
    cur_word = '0;
    prev_word = '0;
    prev_ok = 1'b0;
    exp_under = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    apply_reset(3);
    repeat (20) step(0, 1'b0, 24'h0, -1);
  endtask

  task automatic test_frame_timing();
    repeat (2 * FRAME + 10) step(0, 1'b0, 24'h0, -1);
  endtask

  task automatic test_vesa_red();
    logic [6:0] o0, o1, o2, o3, oc;
    apply_reset(2);
    repeat (7) step(0, 1'b1, 24'hFF0000, -1);
    o0 = '0; o1 = '0; o2 = '0; o3 = '0; oc = '0;
    for (int k = 0; k < 7; k++) begin
      #2;
      o0 = {o0[5:0], dout[0]};
      o1 = {o1[5:0], dout[1]};
      o2 = {o2[5:0], dout[2]};
      o3 = {o3[5:0], dout[3]};
      oc = {oc[5:0], clkout};
      step(0, 1'b1, 24'hFF0000, -1);
    end
    checks++;
    if (o0 !== 7'b0111111) begin errors++; $display("FAIL red_lane0 got %b expected 0111111", o0); end
    checks++;
    if (o1 !== 7'b0000000) begin errors++; $display("FAIL red_lane1 got %b expected 0000000", o1); end
    checks++;
    if (o2 !== {1'b1, ~SP, ~SP, 4'b0000}) begin
      errors++;
      $display("FAIL red_lane2 got %b expected %b", o2, {1'b1, ~SP, ~SP, 4'b0000});
    end
    checks++;
    if (o3 !== 7'b0000011) begin errors++; $display("FAIL red_lane3 got %b expected 0000011", o3); end
    checks++;
    if (oc !== 7'b1100011) begin errors++; $display("FAIL clk_lane got %b expected 1100011", oc); end
    repeat (FRAME) step(0, 1'b1, 24'hFF0000, -1);
  endtask

  task automatic test_underrun();
    apply_reset(2);
    repeat (FRAME + FRAME / 2) step(0, 1'b0, 24'h0, 1);
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_sticky got %b expected 1", underrun);
    end
  endtask

  task automatic test_random_drops();
    repeat (FRAME) step(30, 1'b0, 24'h0, -1);
  endtask

  task automatic test_midframe_reset();
    repeat (16) step(0, 1'b0, 24'h0, -1);
    apply_reset(3);
    repeat (FRAME + 20) step(10, 1'b0, 24'h0, -1);
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_vesa_red();
    test_underrun();
    test_random_drops();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
